// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the fetch/decode boundary: bubble encoding,
// the IF/ID payload bundle and the skid-buffer occupancy encodings.
package rv_pipe_pkg;

  localparam int unsigned PC_WIDTH_C    = 64;
  localparam int unsigned INSTR_WIDTH_C = 32;
  localparam logic [31:0] NOP_INSTR_C   = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [PC_WIDTH_C-1:0]    pc;
    logic [INSTR_WIDTH_C-1:0] instr;
    logic                     pred_taken;
  } if_id_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-to-decode handshake bundle around the IF/ID register.
// The slave modport is the register's view; master is the surrounding pipeline.
interface if_id_skid_reg_if #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [PC_WIDTH-1:0]    PC_in;
  logic [INSTR_WIDTH-1:0] instruction_in;
  logic                   pred_taken_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    PC_out;
  logic [INSTR_WIDTH-1:0] instruction_out;
  logic                   pred_taken_out;

  modport slave (
    input  in_valid, PC_in, instruction_in, pred_taken_in, out_ready,
    output in_ready, out_valid, PC_out, instruction_out, pred_taken_out
  );

  modport master (
    output in_valid, PC_in, instruction_in, pred_taken_in, out_ready,
    input  in_ready, out_valid, PC_out, instruction_out, pred_taken_out
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Payload-agnostic 2-entry skid buffer with synchronous flush. in_ready is a
// flop, so downstream ready never reaches upstream combinationally.
module pipe_skid_buf
  import rv_pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  occ_e         state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q;
  logic         accept, pop;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (accept) begin
        main_d  = in_data;
        state_d = BUSY;
      end
      BUSY: begin
        if (pop && accept) begin
          main_d = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: if (pop) begin
        main_d  = skid_q;
        state_d = BUSY;
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards held and incoming entries; main keeps its stale payload.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // NOTE: the skid entry is never observable before being written, so it has no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: skid-buffered valid/ready transfer of
// {PC, instruction, prediction hint}, with a NOP bubble whenever invalid.
module if_id_skid_reg
  import rv_pipe_pkg::*;
#(
  parameter int unsigned            PC_WIDTH    = PC_WIDTH_C,
  parameter int unsigned            INSTR_WIDTH = INSTR_WIDTH_C,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_C)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  if_id_skid_reg_if.slave      bus,
  output logic [1:0]           occupancy
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   pred_taken;
  } payload_t;

  payload_t in_pl, head_pl;
  logic     head_valid;

  assign in_pl = '{pc: bus.PC_in, instr: bus.instruction_in, pred_taken: bus.pred_taken_in};

  pipe_skid_buf #(.W($bits(payload_t))) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_pl),
    .out_valid (head_valid),
    .out_ready (bus.out_ready),
    .out_data  (head_pl),
    .occupancy (occupancy)
  );

  // PC passes through raw; it is meaningless while the output is invalid.
  assign bus.out_valid       = head_valid;
  assign bus.PC_out          = head_pl.pc;
  assign bus.instruction_out = head_valid ? head_pl.instr : NOP_INSTR;
  assign bus.pred_taken_out  = head_valid & head_pl.pred_taken;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and scoreboarded checks of the IF/ID skid register.
module tb_if_id_skid_reg;
  import rv_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;
  int         n_assert = 0;
  int         n_fail   = 0;

  if_id_skid_reg_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  if_id_skid_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc);
    bus.in_valid       = v;
    bus.PC_in          = pc;
    bus.instruction_in = instr_of(pc);
    bus.pred_taken_in  = pc[2];
  endtask

  task automatic check_head(input string tag, input logic [63:0] pc);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_pc"}, bus.PC_out, pc);
    check({tag, "_instr"}, 64'(bus.instruction_out), 64'(instr_of(pc)));
    check({tag, "_pred"}, 64'(bus.pred_taken_out), 64'(pc[2]));
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_instr"}, 64'(bus.instruction_out), 64'h13);
    check({tag, "_pred"}, 64'(bus.pred_taken_out), 64'd0);
    check({tag, "_occ"}, 64'(occupancy), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  if_id_payload_t sb[$];
  if_id_payload_t expd;
  logic           acc, pp;
  logic [63:0]    rpc;

  initial begin
    rst = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 64'h0);

    // 1. reset then idle
    step(); step();
    rst = 1'b0;
    step();
    check_bubble("reset");
    check("reset_pc", bus.PC_out, 64'h0);

    // 2. streaming at one per cycle
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h1000); step();
    check_head("s0", 64'h1000); check("s0_occ", 64'(occupancy), 64'd1);
    drive(1'b1, 64'h1004); step();
    check_head("s1", 64'h1004); check("s1_occ", 64'(occupancy), 64'd1);
    drive(1'b1, 64'h1008); step();
    check_head("s2", 64'h1008); check("s2_occ", 64'(occupancy), 64'd1);
    drive(1'b0, 64'h0); step();
    check_bubble("s_drain");

    // 3. backpressure fills skid, then drains in order
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h2000); step();
    check("b0_occ", 64'(occupancy), 64'd1);
    drive(1'b1, 64'h2004); step();
    check("b1_occ", 64'(occupancy), 64'd2);
    check("b1_in_ready", 64'(bus.in_ready), 64'd0);
    check_head("b1", 64'h2000);
    drive(1'b1, 64'h2008); step();
    check("b_hold_occ", 64'(occupancy), 64'd2);
    check_head("b_hold", 64'h2000);
    drive(1'b0, 64'h0); bus.out_ready = 1'b1; step();
    check_head("b2", 64'h2004);
    check("b2_occ", 64'(occupancy), 64'd1);
    check("b2_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    check_bubble("b_drain");

    // 4. flush while full drops everything, including the entry in flight
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h2F00); step();
    drive(1'b1, 64'h2F04); step();
    check("f_full_occ", 64'(occupancy), 64'd2);
    drive(1'b1, 64'h3000); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 64'h0);
    check_bubble("flush");
    check("flush_pc_held", bus.PC_out, 64'h2F00);
    bus.out_ready = 1'b1; step();
    check("flush_after_valid", 64'(bus.out_valid), 64'd0);

    // 5. pop and accept together in BUSY
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h4000); step();
    check_head("pa0", 64'h4000);
    bus.out_ready = 1'b1; drive(1'b1, 64'h4004); step();
    check_head("pa1", 64'h4004);
    check("pa1_occ", 64'(occupancy), 64'd1);
    drive(1'b0, 64'h0); step();

    // 6. reset while full with a pop and transfer pending
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h5000); step();
    drive(1'b1, 64'h5004); step();
    check("r_full_occ", 64'(occupancy), 64'd2);
    rst = 1'b1; bus.out_ready = 1'b1; drive(1'b1, 64'h5008); step();
    rst = 1'b0; drive(1'b0, 64'h0);
    check_bubble("mid_reset");
    check("mid_reset_pc", bus.PC_out, 64'h0);

    // Random traffic against an ordered scoreboard
    for (int i = 0; i < 400; i++) begin
      rpc = {32'h0, $urandom};
      bus.in_valid       = 1'($urandom_range(0, 1));
      bus.PC_in          = rpc;
      bus.instruction_in = $urandom;
      bus.pred_taken_in  = 1'($urandom_range(0, 1));
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      #1;
      acc = bus.in_valid && bus.in_ready;
      pp  = bus.out_valid && bus.out_ready;
      if (pp) begin
        if (sb.size() == 0) begin
          check("rnd_spurious_pop", 64'd1, 64'(sb.size()));
        end else begin
          expd = sb.pop_front();
          check("rnd_pc", bus.PC_out, expd.pc);
          check("rnd_instr", 64'(bus.instruction_out), 64'(expd.instr));
          check("rnd_pred", 64'(bus.pred_taken_out), 64'(expd.pred_taken));
        end
      end
      if (acc) sb.push_back('{pc: bus.PC_in, instr: bus.instruction_in, pred_taken: bus.pred_taken_in});
      step();
      check("rnd_occ", 64'(occupancy), 64'(sb.size()));
      check("rnd_in_ready", 64'(bus.in_ready), 64'(sb.size() != 2));
      check("rnd_out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
Next-generation IF/ID pipeline register with a valid/ready handshake in place of a bare stall input. It adds a 2-entry skid buffer, so a backpressuring decode stage can be registered without a combinational ready path back to fetch. It supports a synchronous flush for branch or exception redirect, and inserts a canonical NOP bubble whenever the output is not valid. It sits between the fetch unit and the decoder in the five-stage pipeline.

Parameters:
PC_WIDTH, 64, width of the program counter carried with each instruction.
INSTR_WIDTH, 32, instruction word width.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on instruction_out when out_valid=0.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; synchronous, active-high.
flush  in  1  synchronous kill of all held entries.
in_valid  in  1  fetch presents a valid instruction.
in_ready  out  1  register can accept; registered, depends only on state.
PC_in  in  PC_WIDTH  PC of the incoming instruction.
instruction_in  in  INSTR_WIDTH  incoming instruction.
pred_taken_in  in  1  branch-predictor taken hint for the incoming instruction.
out_valid  out  1  decode-side entry valid.
out_ready  in  1  decode accepts this cycle (0 = stall).
PC_out  out  PC_WIDTH  PC of the head entry.
instruction_out  out  INSTR_WIDTH  head instruction, or NOP_INSTR when out_valid=0.
pred_taken_out  out  1  head prediction hint; 0 when out_valid=0.
occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Reset (rst=1 at a clock edge) produces: out_valid=0, PC_out=0, instruction_out=NOP_INSTR, pred_taken_out=0, occupancy=0, in_ready=1. Reset overrides flush and all handshakes, including mid-transfer.
- Storage: a main register drives the outputs; a skid register holds one overflow entry.
- Accept: a transfer occurs when in_valid && in_ready. Pop: a transfer occurs when out_valid && out_ready.
- States are encoded by occupancy:
  - EMPTY (0): accept -> BUSY; the entry is loaded into main and visible the next cycle (1-cycle latency).
  - BUSY (1): accept without pop -> FULL (entry to skid). Pop with accept -> BUSY (main reloaded from input). Pop without accept -> EMPTY. Neither -> hold.
  - FULL (2): in_ready=0. Pop -> BUSY with main<=skid; the input is not accepted that cycle. No pop -> hold both entries.
- in_ready = (occupancy != 2), driven from a register; there is no combinational path from out_ready to in_ready.
- Throughput is 1 instruction per cycle when out_ready is held high. Ordering is strict FIFO.
- Flush:
  - Flush at a clock edge forces occupancy to 0, out_valid to 0, instruction_out to NOP_INSTR and pred_taken_out to 0.
  - A transfer presented in the flush cycle is dropped.
  - A pop in the flush cycle still counts as consumed for decode.
  - PC_out holds its last value; it is don't-care while invalid.
- While out_valid=0, instruction_out=NOP_INSTR at all times, including after a pop empties the register.
- Payload fields (PC, instruction, hint) move together as one bundle; no field may update independently.
- Legacy stall is expressed by out_ready=0; with in_valid constantly 1, behaviour then matches the old single-register IF/ID plus one buffered entry.

Decomposition:
- Shared package rv_pipe_pkg holds NOP_INSTR_C (32'h13), a packed struct if_id_payload_t {pc, instr, pred_taken}, and the occupancy encodings EMPTY/BUSY/FULL.
- One sub-module is natural: pipe_skid_buf #(W), a payload-agnostic 2-entry skid buffer with flush. if_id_skid_reg instantiates it with W=$bits(if_id_payload_t) and adds the NOP-bubble output muxing.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then 0 -> out_valid=0, instruction_out=32'h13, PC_out=0, in_ready=1, occupancy=0.
2. Streaming: out_ready=1, PC 0x1000/0x1004/0x1008 on consecutive cycles -> the same PCs appear one cycle later, back-to-back, with occupancy stuck at 1.
3. Backpressure: out_ready=0 while 0x2000 and 0x2004 are sent -> occupancy=2 and in_ready=0 the next cycle. Set out_ready=1 -> 0x2000 then 0x2004 are delivered, in_ready returns to 1, and no entry is lost or duplicated.
4. Flush while full: occupancy=2, flush=1 with in_valid=1 carrying PC 0x3000 -> next cycle occupancy=0, out_valid=0, instruction_out=32'h13. PC 0x3000 is never output.
5. Simultaneous pop and accept in BUSY: head 0x4000, input 0x4004, out_ready=1 -> next cycle PC_out=0x4004, occupancy=1.
6. Reset mid-operation: occupancy=2, and rst=1 together with flush=0 and out_ready=1 -> all outputs return to their reset values the next cycle. Random valid/ready traffic is then checked against a scoreboard for order.
